// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative decrypt core.
// Contents: NR and DEFAULT_KEY constants, decrypt FSM state enum, forward and
// inverse S-box lookups, and GF(2^8) helpers xtime/gmul (polynomial 0x11b).
package aes_pkg;

  localparam int NR = 10;
  localparam logic [127:0] DEFAULT_KEY = 128'h000102030405060708090a0b0c0d0e0f;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  // Entry x sits at bits [2047-8x -: 8].
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX_TABLE[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply; constant operands fold to a few XORs.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_decrypt_iter_round.sv
// One inverse AES round and its leaf transforms, all combinational.
// decrypt_round ports: in_state  - round input state
//                      round_key - key added after InvSubBytes
//                      last      - 1 skips InvMixColumns (final round)
//                      out_state - round output state
// Byte i of a state sits at [127-8i -: 8]; column c = bytes 4c..4c+3.
module inv_shift_rows (
  input  logic [127:0] in_state,
  output logic [127:0] out_state
);
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_byte
      // row r rotates right by r: output column c takes input column c-r
      localparam int C   = gi / 4;
      localparam int R   = gi % 4;
      localparam int SRC = 4 * ((C + 4 - R) % 4) + R;
      assign out_state[127-8*gi -: 8] = in_state[127-8*SRC -: 8];
    end
  endgenerate
endmodule

module inv_sub_bytes
  import aes_pkg::*;
(
  input  logic [127:0] in_state,
  output logic [127:0] out_state
);
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_byte
      assign out_state[127-8*gi -: 8] = inv_sbox(in_state[127-8*gi -: 8]);
    end
  endgenerate
endmodule

module inv_mix_columns
  import aes_pkg::*;
(
  input  logic [127:0] in_state,
  output logic [127:0] out_state
);
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_col
      logic [7:0] a0, a1, a2, a3;
      assign a0 = in_state[127-32*gi -: 8];
      assign a1 = in_state[119-32*gi -: 8];
      assign a2 = in_state[111-32*gi -: 8];
      assign a3 = in_state[103-32*gi -: 8];
      assign out_state[127-32*gi -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      assign out_state[119-32*gi -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      assign out_state[111-32*gi -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      assign out_state[103-32*gi -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
  endgenerate
endmodule

module decrypt_round (
  input  logic [127:0] in_state,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] out_state
);
  logic [127:0] shifted;
  logic [127:0] subbed;
  logic [127:0] keyed;
  logic [127:0] mixed;

  inv_shift_rows  u_inv_shift_rows  (.in_state(in_state), .out_state(shifted));
  inv_sub_bytes   u_inv_sub_bytes   (.in_state(shifted),  .out_state(subbed));

  assign keyed = subbed ^ round_key;

  inv_mix_columns u_inv_mix_columns (.in_state(keyed),    .out_state(mixed));

  assign out_state = last ? keyed : mixed;
endmodule

// File: rtl/key_expansion.sv
// AES-128 key schedule, purely combinational.
// Ports: key      - 128-bit cipher key
//        fullkeys - 11 round keys, round key r at [1407-128*r -: 128]
module key_expansion
  import aes_pkg::*;
(
  input  logic [127:0]  key,
  output logic [1407:0] fullkeys
);

  function automatic logic [1407:0] expand_key(input logic [127:0] k);
    logic [31:0]   w [0:43];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1407:0] fk;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        // RotWord then SubWord, then fold in the round constant
        t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rcon, 24'h000000};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) fk[1407-32*i -: 32] = w[i];
    return fk;
  endfunction

  assign fullkeys = expand_key(key);

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryption, one inverse round per clock.
// Ports: clk       - rising-edge clock
//        rst_n     - asynchronous active-low reset
//        start     - request, accepted only in IDLE
//        in        - ciphertext, captured on the accepted-start edge
//        out       - plaintext, held until the next result overwrites it
//        done_decr - one-cycle pulse when out becomes valid
//        busy      - high while rounds are being computed
module aes_decrypt_iter #(
  parameter logic [127:0] KEY = aes_pkg::DEFAULT_KEY,
  parameter int           NR  = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] in,
  output logic [127:0] out,
  output logic         done_decr,
  output logic         busy
);
  import aes_pkg::*;

  localparam logic [3:0] FIRST_CNT = 4'(NR - 1);

  fsm_t          fsm_reg, fsm_next;
  logic [3:0]    cnt_reg;
  logic [127:0]  state_reg;
  logic [127:0]  out_reg;
  logic [1407:0] fullkeys;
  logic [127:0]  rk [0:10];
  logic [127:0]  round_out;

  key_expansion u_key_expansion (.key(KEY), .fullkeys(fullkeys));

  genvar gi;
  generate
    for (gi = 0; gi <= 10; gi++) begin : g_rk
      assign rk[gi] = fullkeys[1407-128*gi -: 128];
    end
  endgenerate

  // Round keys are consumed in reverse order; cnt_reg indexes them directly.
  decrypt_round u_decrypt_round (
    .in_state (state_reg),
    .round_key(rk[cnt_reg]),
    .last     (cnt_reg == 4'd0),
    .out_state(round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg   <= IDLE;
      cnt_reg   <= 4'd0;
      state_reg <= 128'd0;
      out_reg   <= 128'd0;
    end else begin
      fsm_reg <= fsm_next;
      case (fsm_reg)
        IDLE: begin
          if (start) begin
            state_reg <= in ^ rk[NR];
            cnt_reg   <= FIRST_CNT;
          end
        end
        ROUND: begin
          if (cnt_reg == 4'd0) begin
            out_reg <= round_out;
          end else begin
            state_reg <= round_out;
            cnt_reg   <= cnt_reg - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    fsm_next = fsm_reg;
    case (fsm_reg)
      IDLE:    if (start) fsm_next = ROUND;
      ROUND:   if (cnt_reg == 4'd0) fsm_next = DONE;
      DONE:    fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  // Status flags decode straight from the state register, so they are
  // glitch-free and clear together with the asynchronous reset.
  always_comb begin
    busy      = (fsm_reg == ROUND);
    done_decr = (fsm_reg == DONE);
    out       = out_reg;
  end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Self-checking bench for aes_decrypt_iter: FIPS-197 C.1, random round trips
// through an independent encryption model, busy/done timing, ignored starts,
// async reset mid-run, output hold, and start held high.
module tb_aes_decrypt_iter;

  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] TB_KEY = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] in;
  logic [127:0] out;
  logic         done_decr;
  logic         busy;

  int total = 0;
  int bad   = 0;

  logic [7:0]   sb [256];
  logic [127:0] rk_model [11];

  aes_decrypt_iter #(.KEY(TB_KEY)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in       (in),
    .out      (out),
    .done_decr(done_decr),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (FIPS-197 encryption) ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (prod[i]) prod = prod ^ (15'h11b << (i - 8));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic build_model();
    logic [7:0]  inv;
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gf_mul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = TB_KEY[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_model[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] p);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [127:0] v;
    v = p ^ rk_model[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[v[127-8*i -: 8]];
      // row q rotates left by q
      for (int i = 0; i < 16; i++) t[i] = s[4*(((i/4) + (i%4)) % 4) + (i%4)];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int q = 0; q < 4; q++) a[q] = t[4*c+q];
          for (int q = 0; q < 4; q++)
            t[4*c+q] = gf_mul(8'h02, a[q]) ^ gf_mul(8'h03, a[(q+1)%4]) ^ a[(q+2)%4] ^ a[(q+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = t[i];
      v = v ^ rk_model[r];
    end
    return v;
  endfunction

  // Start one decryption and follow it to completion.
  // lat counts falling edges from start assertion until done_decr is seen.
  task automatic do_op(input logic [127:0] ct, input bit poke, output logic [127:0] res,
                       output int lat, output int busy_cyc, output logic done_after);
    start = 1'b1;
    in = ct;
    lat = 0;
    busy_cyc = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) busy_cyc++;
      start = poke && (lat == 4);
      in = (poke && lat == 4) ? 128'd0 : 'x;
    end while (!done_decr && lat < 40);
    res = out;
    start = 1'b0;
    @(negedge clk);
    done_after = done_decr;
    $display("txn ct=%h pt=%h lat=%0d busy=%0d", ct, res, lat, busy_cyc);
  endtask

  logic [127:0] res;
  logic [127:0] pt;
  logic         done_after;
  int           lat;
  int           busy_cyc;
  logic [127:0] pts [0:60];
  int           next_acc;
  int           last_acc;
  logic         exp_done;

  initial begin
    build_model();
    rst_n = 1'b0;
    start = 1'b0;
    in = '0;
    repeat (2) @(negedge clk);
    check("reset_out", out, 128'd0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done_decr, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 C.1
    do_op(C1_CT, 1'b0, res, lat, busy_cyc, done_after);
    check("c1_out", res, C1_PT);
    check("c1_latency", lat, 11);
    check("c1_busy_cycles", busy_cyc, 10);
    check("c1_done_width", done_after, 1'b0);

    // output holds with start low
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_out", out, C1_PT);
      check("hold_done", done_decr, 1'b0);
    end

    // random round trips
    for (int i = 0; i < 1000; i++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      do_op(aes_enc(pt), 1'b0, res, lat, busy_cyc, done_after);
      check("rt_out", res, pt);
      check("rt_latency", lat, 11);
      check("rt_done_width", done_after, 1'b0);
    end

    // second start while busy is ignored
    do_op(C1_CT, 1'b1, res, lat, busy_cyc, done_after);
    check("poke_out", res, C1_PT);
    check("poke_latency", lat, 11);
    check("poke_busy_cycles", busy_cyc, 10);
    check("poke_done_width", done_after, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("poke_no_second_done", done_decr, 1'b0);
    end

    // asynchronous reset in the middle of a run
    start = 1'b1;
    in = C1_CT;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out", out, 128'd0);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done_decr, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(C1_CT, 1'b0, res, lat, busy_cyc, done_after);
    check("post_reset_out", res, C1_PT);
    check("post_reset_latency", lat, 11);

    // start held high: one accept every 12 cycles, each with its own input
    next_acc = 0;
    last_acc = -100;
    for (int m = 0; m <= 60; m++) begin
      exp_done = (m == last_acc + 11);
      check("held_done", done_decr, exp_done);
      if (exp_done) check("held_out", out, pts[last_acc]);
      pts[m] = {$urandom, $urandom, $urandom, $urandom};
      start = 1'b1;
      in = aes_enc(pts[m]);
      if (m == next_acc) begin
        last_acc = m;
        next_acc = m + 12;
      end
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
